// File: rtl/b_link_responder_pkg.sv
// Shared constants for the A<->B point-to-point link, B-side view.
package b_link_responder_pkg;

    // Link widths shared with the A-side block.
    localparam int LINK_A2B_W   = 8;
    localparam int LINK_B2A_W   = 12;
    localparam int LINK_EXTRA_W = 4;

    // Width of the wrapping sequence tag added to each response.
    localparam int SEQ_W = 4;

    // Field offsets inside a B-to-A response word.
    localparam int PAYLOAD_LSB = 0;
    localparam int SEQ_LSB     = LINK_A2B_W;

    // Buffered entry layout: {seq, extra, payload}.
    localparam int ENTRY_W = SEQ_W + LINK_EXTRA_W + LINK_A2B_W;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/b_link_responder_link_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read of the head entry.
module link_sync_fifo #(
    parameter int ENTRY_W = b_link_responder_pkg::ENTRY_W,
    parameter int DEPTH   = 4,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] pop_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    // Head is read combinationally so the output slot can load it on the same edge.
    assign pop_data = mem[rd_ptr_reg];

    // Guard the requests so an overflow or underflow can never corrupt state.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/b_link_responder.sv
// B-side link endpoint: buffers tagged requests and returns one response per request, in order.
module b_link_responder #(
    parameter int A2B_W   = b_link_responder_pkg::LINK_A2B_W,
    parameter int B2A_W   = b_link_responder_pkg::LINK_B2A_W,
    parameter int EXTRA_W = b_link_responder_pkg::LINK_EXTRA_W,
    parameter int SEQ_W   = b_link_responder_pkg::SEQ_W,
    parameter int DEPTH   = 4,
    localparam int LVL_W  = $clog2(DEPTH + 1) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A2B_W-1:0]   req_data,
    input  logic [EXTRA_W-1:0] req_extra,
    input  logic               req_valid,
    output logic               req_ready,
    output logic [B2A_W-1:0]   rsp_data,
    output logic [EXTRA_W-1:0] rsp_extra,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [LVL_W-1:0]   level,
    output logic [SEQ_W-1:0]   seq_next
);
    import b_link_responder_pkg::*;

    localparam int E_W             = SEQ_W + EXTRA_W + A2B_W;
    localparam int CNT_W           = $clog2(DEPTH + 1);
    localparam int RSP_PAYLOAD_LSB = PAYLOAD_LSB;
    localparam int RSP_SEQ_LSB     = RSP_PAYLOAD_LSB + A2B_W;

    // Refuse to elaborate a configuration that cannot hold the tagged payload.
    if ((B2A_W < A2B_W + SEQ_W) || !is_pow2(DEPTH) || (DEPTH < 2)) begin : g_cfg_error
        $error("b_link_responder: need B2A_W >= A2B_W + SEQ_W and DEPTH a power of two >= 2");
    end

    logic [SEQ_W-1:0]   seq_reg;
    logic               rsp_valid_reg;
    logic [B2A_W-1:0]   rsp_data_reg;
    logic [EXTRA_W-1:0] rsp_extra_reg;
    logic [B2A_W-1:0]   rsp_data_next;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [E_W-1:0]     fifo_head;
    logic [E_W-1:0]     entry_in;

    // Ready depends only on registered occupancy (and reset), never on rsp_ready/req_valid.
    assign req_ready = !rst && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    // Load the output slot whenever it is empty or being drained this edge.
    assign fifo_pop  = !fifo_empty && (!rsp_valid_reg || rsp_ready);
    assign entry_in  = {seq_reg, req_extra, req_data};

    link_sync_fifo #(
        .ENTRY_W (E_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (entry_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Pack the head entry into a response word: payload low, tag above it, zero fill on top.
    always_comb begin
        rsp_data_next = '0;
        rsp_data_next[RSP_PAYLOAD_LSB +: A2B_W] = fifo_head[A2B_W-1:0];
        rsp_data_next[RSP_SEQ_LSB +: SEQ_W]     = fifo_head[E_W-1 -: SEQ_W];
    end

    // Sequence tag advances once per accepted request and wraps at 2^SEQ_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_reg <= '0;
        end else if (fifo_push) begin
            seq_reg <= seq_reg + 1'b1;
        end
    end

    // Output slot: load from the FIFO head when free or draining, else clear on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_extra_reg <= '0;
        end else if (fifo_pop) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= rsp_data_next;
            rsp_extra_reg <= fifo_head[A2B_W +: EXTRA_W];
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_extra = rsp_extra_reg;
    assign seq_next  = seq_reg;
    assign level     = LVL_W'(fifo_count) + LVL_W'(rsp_valid_reg);

endmodule

// File: tb/tb_b_link_responder.sv
// Randomized scoreboard bench for b_link_responder at default widths.
module tb_b_link_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req_data = '0;
    logic [3:0]  req_extra = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] rsp_data;
    logic [3:0]  rsp_extra;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  level;
    logic [3:0]  seq_next;

    always #5 clk = ~clk;

    b_link_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_extra (req_extra),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_data  (rsp_data),
        .rsp_extra (rsp_extra),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .level     (level),
        .seq_next  (seq_next)
    );

    typedef struct {
        int data;
        int extra;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: buffered-item count, output-slot occupancy and next tag.
    int fifo_n    = 0;
    bit slot_v    = 1'b0;
    int model_seq = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic cycle(input bit v, input int d, input int e, input bit r, output bit acc);
        bit load;
        req_valid = v;
        req_data  = 8'(d);
        req_extra = 4'(e);
        rsp_ready = r;
        @(negedge clk);
        check("req_ready", int'(req_ready), int'(fifo_n != DEPTH));
        check("level", int'(level), fifo_n + int'(slot_v));
        check("rsp_valid", int'(rsp_valid), int'(slot_v));
        check("seq_next", int'(seq_next), model_seq);
        acc = v && (fifo_n != DEPTH);
        if (acc) begin
            exp_q.push_back('{data: model_seq * 256 + (d % 256), extra: e % 16});
            $display("req  data=0x%02h extra=0x%0h tag=%0d", d % 256, e % 16, model_seq);
        end
        @(posedge clk);
        load   = (fifo_n > 0) && (!slot_v || r);
        slot_v = load || (slot_v && !r);
        fifo_n = fifo_n + int'(acc) - int'(load);
        if (acc) model_seq = (model_seq + 1) % 16;
        #1;
    endtask

    task automatic idle(input int n, input int rmode);
        bit acc;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 0, 0, (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode), acc);
        end
    endtask

    // Present one request until accepted, within a bounded number of cycles.
    task automatic send(input int d, input int e, input int rmode);
        bit acc;
        for (int t = 0; t < 40; t++) begin
            cycle(1'b1, d, e, (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode), acc);
            if (acc) return;
        end
        check("accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    // Mid-cycle asynchronous reset pulse; outputs must clear before the next edge.
    task automatic do_reset();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_extra", int'(rsp_extra), 0);
        check("rst_level", int'(level), 0);
        check("rst_seq_next", int'(seq_next), 0);
        check("rst_req_ready", int'(req_ready), 0);
        exp_q.delete();
        fifo_n    = 0;
        slot_v    = 1'b0;
        model_seq = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each response handshake and checks stall stability.
    initial begin
        bit          stall = 1'b0;
        logic [11:0] prev_d = '0;
        logic [3:0]  prev_e = '0;
        exp_t        x;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_data", int'(rsp_data), int'(prev_d));
                    check("hold_extra", int'(rsp_extra), int'(prev_e));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        $display("rsp  data=0x%03h extra=0x%0h", rsp_data, rsp_extra);
                        check("rsp_data", int'(rsp_data), x.data);
                        check("rsp_extra", int'(rsp_extra), x.extra);
                    end
                end
                stall  = rsp_valid && !rsp_ready;
                prev_d = rsp_data;
                prev_e = rsp_extra;
            end
        end
    end

    initial begin
        bit acc;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1, 0);
        do_reset();

        // Single request straight after reset.
        send(8'hA5, 4'h3, 1);
        idle(4, 1);

        // Fill with the consumer stalled: five fit, the sixth waits.
        for (int i = 1; i <= 5; i++) send(i, i, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 6, 6, 1'b0, acc);
        send(6, 6, 1);
        idle(8, 1);

        // Back-to-back streaming with the tag wrapping.
        for (int i = 0; i < 20; i++) send((i * 7 + 3) % 256, i % 16, 1);
        idle(6, 1);

        // Random consumer stalls and request gaps.
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1, 2);
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 2);
        end
        idle(20, 1);
        check("drain_empty", exp_q.size(), 0);

        // Reset with three entries held, then the tag restarts at zero.
        for (int i = 0; i < 3; i++) send(8'h30 + i, i, 0);
        do_reset();
        send(8'h5C, 4'h9, 1);
        idle(4, 1);
        check("final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/b_link_responder.md
Name: b_link_responder

Overview:
- B-side endpoint of the A<->B point-to-point link; the opposite end of the A-side block.
- Accepts A-to-B words plus their A-extra sideband through a valid/ready handshake and buffers them in a small FIFO.
- Returns one B-to-A response word per accepted request, in order: the received payload tagged with a wrapping sequence number, with the sideband echoed back.
- Sits at the B boundary of the link; the top level sets the widths from the shared link-width constants.

Parameters:
- A2B_W, 8, width of an A-to-B request payload; top level sets it to the A-to-B link width.
- B2A_W, 12, width of a B-to-A response word; top level sets it to the B-to-A link width; must satisfy B2A_W >= A2B_W + SEQ_W.
- EXTRA_W, 4, width of the A-extra sideband carried with each request.
- SEQ_W, 4, width of the sequence tag.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_data  in  A2B_W  request payload from A.
- req_extra  in  EXTRA_W  A-extra sideband, qualified by req_valid.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_data  out  B2A_W  response word to A.
- rsp_extra  out  EXTRA_W  echoed sideband.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  A consumes the response.
- level  out  $clog2(DEPTH+1)+1  occupied entries: FIFO count plus the output register.
- seq_next  out  SEQ_W  tag that the next accepted request will receive.

Behaviour:
- Reset, asynchronous, active-high. While rst is high:
  - FIFO pointers, FIFO count, output register valid and sequence counter are all 0.
  - rsp_valid=0, rsp_data=0, rsp_extra=0, level=0, seq_next=0.
  - req_ready=0.
  - Reset mid-transfer discards all buffered entries; no response is emitted for them.
- req_ready:
  - Equals !rst && (fifo_count != DEPTH), from registered state only.
  - Has no combinational path from rsp_ready or req_valid.
- Accept:
  - Occurs on a rising edge with req_valid && req_ready.
  - Writes {seq, req_extra, req_data} into the FIFO tail.
  - seq increments modulo 2^SEQ_W (wraps 15 -> 0 at the default width).
- Response word:
  - rsp_data = {zero-fill, seq_tag[SEQ_W-1:0], req_data[A2B_W-1:0]}.
  - Payload occupies bits [A2B_W-1:0]; the tag occupies the next SEQ_W bits; the upper bits are 0.
- Output stage:
  - Registered output slot (rsp_valid, rsp_data, rsp_extra).
  - The slot loads from the FIFO head on an edge where the FIFO is non-empty and (!rsp_valid || rsp_ready).
  - Otherwise, rsp_ready && rsp_valid clears rsp_valid.
  - rsp_data and rsp_extra hold stable while rsp_valid && !rsp_ready.
- Latency:
  - A request accepted at edge N shows rsp_valid high after edge N+1 when the output slot is free.
  - With back-to-back accepts and rsp_ready held at 1, throughput is one response per cycle.
- Total capacity is DEPTH+1 (FIFO plus output slot).
- Simultaneous FIFO push and pop:
  - Count unchanged; both pointers advance.
  - Legal when the FIFO is full only if req_ready was already 1. It is not, so there is no push while full.
- Pop while empty: no action. The output slot keeps its state; rsp_valid falls after handshake.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO; no response is dropped, duplicated or reordered.
- level = fifo_count + rsp_valid, updated every edge.
- Elaboration check: an assertion fails if B2A_W < A2B_W + SEQ_W or DEPTH is not a power of two.

Decomposition:
- Shared package:
  - Link width constants (A-to-B width, B-to-A width, extra width).
  - SEQ_W.
  - Response field offsets (PAYLOAD_LSB=0, SEQ_LSB=A2B_W).
  - Entry width constant ENTRY_W = SEQ_W + EXTRA_W + A2B_W.
- Sub-module link_sync_fifo:
  - Parameters: ENTRY_W, DEPTH.
  - Ports: push/pop/full/empty/count.
  - Instantiated once.
- The output slot, sequence counter and packing stay in b_link_responder.

Test Plan:
- Reset and single request:
  - Stimulus: rst pulse mid-cycle; then req_data=0xA5, extra=0x3, valid for 1 cycle; rsp_ready=1.
  - Response: rsp_valid 2 edges after rst deasserts; rsp_data=0x0A5, rsp_extra=0x3; seq_next=1.
  - Also check all outputs are 0 during rst.
- Fill and backpressure:
  - Stimulus: rsp_ready=0; issue 6 requests 0x01..0x06.
  - Response: 5 accepted; req_ready=0 after the 5th; level=5.
  - Then rsp_ready=1: responses 0x001, 0x102, 0x203, 0x304, 0x405 in order; the 6th is accepted after the first pop.
- Streaming:
  - Stimulus: 20 back-to-back requests with rsp_ready=1.
  - Response: one response per cycle after 2-cycle latency.
  - Tag wraps: request 17 carries tag 0; its data is {4'h0, payload}.
- Stall hold:
  - Stimulus: toggle rsp_ready randomly 0/1 over 50 requests.
  - Response: rsp_data and rsp_extra stable while valid && !ready; scoreboard order exact.
- Reset mid-operation:
  - Stimulus: assert rst with level=3.
  - Response: rsp_valid drops immediately (async); level=0; seq_next=0.
  - The next request after reset returns tag 0.
